decode_stage: RTL and testbench

Parametrised RV32/RV64 instruction decode pipeline stage between fetch and execute. Accepts raw 32-bit instructions with PC over a valid/ready handshake, classifies the opcode against the shared `opcodes::opcode_t` encoding, extracts register fields and the sign-extended immediate, and presents a registered decode record downstream. Contains a one-entry skid buffer so `in_ready` is a registered signal, with no combinational path from `out_ready`.

---
 rtl/decode_stage_pkg.sv | 120 ++++++++++++
 rtl/decode_stage_skid.sv | 74 +++++++
 rtl/decode_stage.sv | 40 ++++
 tb/tb_decode_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared opcode encoding and decode record for the RV32/RV64 decode stage.
// Optional feature macro: DECODE_ILLEGAL_EN (flags illegal encodings when defined).
package opcodes;

  // Major opcodes, inst[6:0]
  typedef enum logic [6:0] {
    LOAD      = 7'b0000011,
    MISC_MEM  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    AUIPC     = 7'b0010111,
    OP_IMM_32 = 7'b0011011,
    STORE     = 7'b0100011,
    OP        = 7'b0110011,
    LUI       = 7'b0110111,
    OP_32     = 7'b0111011,
    BRANCH    = 7'b1100011,
    JALR      = 7'b1100111,
    JAL       = 7'b1101111,
    SYSTEM    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  // pc and imm are fixed at 64 bits; for XLEN=32 the upper imm half is zero
  typedef struct packed {
    logic [63:0] pc;
    opcode_t     op;
    fmt_t        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic        rd_we;
    logic        word;
    logic        illegal;
  } decode_t;

  // Pure combinational decode of one instruction
  function automatic decode_t decode_inst(input logic [31:0] inst, input logic [63:0] pc,
                                          input int unsigned xlen);
    decode_t     d;
    logic        legal;
    logic        sgn;
    logic [63:0] imm;
    opcode_t     op;

    op       = opcode_t'(inst[6:0]);
    sgn      = inst[31];
    d        = '0;
    d.pc     = pc;
    d.op     = op;
    d.rd     = inst[11:7];
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    d.funct3 = inst[14:12];
    d.funct7 = inst[31:25];
    d.fmt    = FMT_R;
    imm      = '0;
    legal    = 1'b1;

    case (op)
      OP: d.fmt = FMT_R;
      OP_32: begin
        d.fmt = FMT_R;
        legal = (xlen == 32'd64);
      end
      LOAD, OP_IMM, JALR, MISC_MEM, SYSTEM: begin
        d.fmt = FMT_I;
        imm   = {{52{sgn}}, inst[31:20]};
      end
      OP_IMM_32: begin
        d.fmt = FMT_I;
        imm   = {{52{sgn}}, inst[31:20]};
        legal = (xlen == 32'd64);
      end
      STORE: begin
        d.fmt = FMT_S;
        imm   = {{52{sgn}}, inst[31:25], inst[11:7]};
      end
      BRANCH: begin
        d.fmt = FMT_B;
        imm   = {{52{sgn}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        d.fmt = FMT_U;
        imm   = {{32{sgn}}, inst[31:12], 12'h000};
      end
      JAL: begin
        d.fmt = FMT_J;
        imm   = {{44{sgn}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: legal = 1'b0;
    endcase

    if (xlen == 32'd32) imm[63:32] = '0;
    d.imm  = imm;
    d.word = ((op == OP_IMM_32) || (op == OP_32)) && (xlen == 32'd64);

`ifdef DECODE_ILLEGAL_EN
    d.illegal = ~legal | (inst[1:0] != 2'b11);
`else
    d.illegal = 1'b0;
`endif

    // Unknown opcodes never write back, with or without illegal flagging
    d.rd_we = legal && (d.fmt != FMT_S) && (d.fmt != FMT_B) && (op != MISC_MEM) &&
              (d.rd != 5'd0) && !d.illegal;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_skid.sv
// Two-entry valid/ready register slice (main + skid) carrying a decode record.
// in_ready comes straight from a flop, so out_ready never reaches it combinationally.
module decode_skid
  import opcodes::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  logic    in_valid,
  output logic    in_ready,
  input  decode_t in_data,
  output logic    out_valid,
  input  logic    out_ready,
  output decode_t out_data
);

  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready_q;
  decode_t main_q, main_d;
  decode_t skid_q, skid_d;
  logic    in_fire;
  logic    main_free;

  assign in_fire   = in_valid & in_ready_q;
  assign main_free = ~main_valid_q | out_ready;

  // Next-state: flush clears both, otherwise drain skid first, then accept input
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no input can arrive this cycle
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) main_d = in_data;
      end
    end else if (in_fire) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/decode_stage.sv
// RV32/RV64 decode pipeline stage: combinational decode into a registered skid slice.
// Optional feature macro: DECODE_ILLEGAL_EN (see package opcodes).
module decode_stage
  import opcodes::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output decode_t             out_dec
);

  decode_t dec;

  // Decode the incoming instruction before it is registered
  always_comb begin
    dec = decode_inst(in_inst, 64'(in_pc), XLEN);
  end

  decode_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_dec)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are checked against a queue-based reference of the held instructions.
module tb_decode_stage;
  import opcodes::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready32, in_ready64, out_valid32, out_valid64;
  decode_t     dec32, dec64;

  int ncmp  = 0;
  int nfail = 0;

  decode_t q32[$];
  decode_t q64[$];

`ifdef DECODE_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid32), .out_ready(out_ready),
    .out_dec(dec32)
  );

  decode_stage #(.XLEN(64), .PC_WIDTH(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_dec(dec64)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA rules using numeric opcodes
  function automatic decode_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                         input int x);
    decode_t r;
    longint  simm;
    bit      known, ok_x, legal;
    r        = '0;
    r.pc     = {32'b0, pc};
    r.op     = opcode_t'(inst[6:0]);
    r.rd     = inst[11:7];
    r.rs1    = inst[19:15];
    r.rs2    = inst[24:20];
    r.funct3 = inst[14:12];
    r.funct7 = inst[31:25];
    r.fmt    = FMT_R;
    simm     = 0;
    known    = 1;
    ok_x     = 1;
    case (inst[6:0])
      7'h33: r.fmt = FMT_R;
      7'h3B: begin r.fmt = FMT_R; ok_x = (x == 64); end
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
        r.fmt = FMT_I; simm = longint'($signed(inst[31:20]));
      end
      7'h1B: begin r.fmt = FMT_I; simm = longint'($signed(inst[31:20])); ok_x = (x == 64); end
      7'h23: begin r.fmt = FMT_S; simm = longint'($signed({inst[31:25], inst[11:7]})); end
      7'h63: begin
        r.fmt = FMT_B;
        simm  = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin r.fmt = FMT_U; simm = longint'($signed({inst[31:12], 12'h000})); end
      7'h6F: begin
        r.fmt = FMT_J;
        simm  = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      default: known = 0;
    endcase
    r.imm     = (x == 32) ? {32'b0, simm[31:0]} : simm;
    legal     = known && ok_x;
    r.word    = ((inst[6:0] == 7'h1B) || (inst[6:0] == 7'h3B)) && (x == 64);
    r.illegal = ILL_EN && (!legal || (inst[1:0] != 2'b11));
    r.rd_we   = legal && (r.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (inst[6:0] != 7'h0F)
                && (r.rd != 5'd0);
    return r;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_in_ready32"}, in_ready32, q32.size() < 2);
    chk({tag, "_in_ready64"}, in_ready64, q64.size() < 2);
    chk({tag, "_out_valid32"}, out_valid32, q32.size() > 0);
    chk({tag, "_out_valid64"}, out_valid64, q64.size() > 0);
    if (q32.size() > 0) chk({tag, "_dec32"}, dec32, q32[0]);
    if (q64.size() > 0) chk({tag, "_dec64"}, dec64, q64[0]);
  endtask

  // One clock: drive, advance reference at the edge, check 1 time unit later
  task automatic step(input string tag, input bit v, input logic [31:0] inst,
                      input logic [31:0] pc, input bit ordy, input bit fl);
    bit acc;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc       = v && (q32.size() < 2);
    @(posedge clk);
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if ((q32.size() > 0) && ordy) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        q32.push_back(ref_decode(inst, pc, 32));
        q64.push_back(ref_decode(inst, pc, 64));
      end
    end
    #1;
    check_state(tag);
  endtask

  logic [6:0]  optab [14] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                              7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h00};

  initial begin
    logic [31:0] r, rinst;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_in_ready", in_ready32, 1'b1);
    chk("rst_dec32", dec32, '0);
    chk("rst_dec64", dec64, '0);
    reset = 1'b0;

    // addi x1,x0,5
    step("addi", 1, 32'h0050_0093, 32'h100, 1, 0);
    chk("addi_op", dec32.op, OP_IMM);
    chk("addi_fmt", dec32.fmt, FMT_I);
    chk("addi_rd", dec32.rd, 5'd1);
    chk("addi_imm", dec32.imm, 64'd5);
    chk("addi_rd_we", dec32.rd_we, 1'b1);

    // beq x0,x0,-4
    step("beq", 1, 32'hFE00_0EE3, 32'h104, 1, 0);
    chk("beq_op", dec32.op, BRANCH);
    chk("beq_fmt", dec32.fmt, FMT_B);
    chk("beq_imm32", dec32.imm, 64'h0000_0000_FFFF_FFFC);
    chk("beq_imm64", dec64.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rd_we", dec32.rd_we, 1'b0);
    step("idle0", 0, 32'h0, 32'h0, 1, 0);

    // Stall: three offered, two taken, third held by fetch until space opens
    step("st_a", 1, 32'h0010_0113, 32'h200, 0, 0);
    step("st_b", 1, 32'h0020_8193, 32'h204, 0, 0);
    chk("st_in_ready_low", in_ready32, 1'b0);
    step("st_c_held", 1, 32'h0031_0213, 32'h208, 0, 0);
    chk("st_head_pc", dec32.pc, 64'h200);
    step("st_drain1", 1, 32'h0031_0213, 32'h208, 1, 0);
    chk("st_pc_b", dec32.pc, 64'h204);
    step("st_drain2", 1, 32'h0031_0213, 32'h208, 1, 0);
    chk("st_pc_c", dec32.pc, 64'h208);
    step("st_drain3", 0, 32'h0, 32'h0, 1, 0);
    chk("st_empty", out_valid32, 1'b0);

    // addiw x1,x1,1
    step("addiw", 1, 32'h0010_809B, 32'h300, 1, 0);
    chk("addiw_op64", dec64.op, OP_IMM_32);
    chk("addiw_word64", dec64.word, 1'b1);
    chk("addiw_imm64", dec64.imm, 64'd1);
    chk("addiw_ill32", dec32.illegal, ILL_EN);
    chk("addiw_rd_we32", dec32.rd_we, 1'b0);

    // All-zero word
    step("zero", 1, 32'h0, 32'h304, 1, 0);
    chk("zero_ill", dec32.illegal, ILL_EN);
    chk("zero_rd_we", dec32.rd_we, 1'b0);
    chk("zero_imm", dec32.imm, 64'd0);

    // Skid full then flush with a live input
    step("fl_a", 1, 32'h0050_0093, 32'h400, 0, 0);
    step("fl_b", 1, 32'h0050_0093, 32'h404, 0, 0);
    step("fl_c", 1, 32'h0050_0093, 32'h408, 0, 1);
    chk("fl_out_valid", out_valid32, 1'b0);
    chk("fl_in_ready", in_ready32, 1'b1);
    for (int i = 0; i < 3; i++) step("fl_after", 0, 32'h0, 32'h0, 1, 0);

    // Reset mid-stream loses held instructions
    step("mr_a", 1, 32'h0000_00EF, 32'h500, 0, 0);
    step("mr_b", 1, 32'h1234_5137, 32'h504, 0, 0);
    reset = 1'b1;
    #2;
    q32.delete();
    q64.delete();
    chk("mr_out_valid", out_valid32, 1'b0);
    chk("mr_in_ready", in_ready64, 1'b1);
    reset = 1'b0;
    step("mr_after", 0, 32'h0, 32'h0, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      r     = $urandom;
      rinst = $urandom;
      if (r[2:0] != 3'd0) rinst[6:0] = optab[$urandom_range(0, 13)];
      step("rnd", $urandom_range(0, 3) != 0, rinst, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
